// File: rtl/neopixel_pkg.sv
// Shared types for the NeoPixel strand path: colour slot encoding, GRB pixel
// layout and the frame sequencer state encoding.
package neopixel_pkg;

  localparam int CLK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    COLOR_RED   = 2'b00,
    COLOR_BLUE  = 2'b01,
    COLOR_GREEN = 2'b10
  } color_idx_t;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_ACK,
    S_DRAIN
  } seq_state_t;

  function automatic logic [7:0] grb_byte(input grb_t px, input color_idx_t c);
    case (c)
      COLOR_RED:  return px.r;
      COLOR_BLUE: return px.b;
      default:    return px.g;
    endcase
  endfunction

endpackage

// File: rtl/counter.sv
// Generic loadable counter: clear wins over enable, enable loads d.
module counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)      q <= '0;
    else if (clear) q <= '0;
    else if (en)    q <= d;
  end

endmodule

// File: rtl/neopixel_frame_sequencer.sv
// Streams a double-buffered GRB frame into the strand controller's load/send
// handshake, on host commit or on a periodic refresh timer.
module neopixel_frame_sequencer
  import neopixel_pkg::*;
#(
  parameter int NUM_PIXELS     = 5,
  parameter int REFRESH_CYCLES = 2_500_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        host_wr,
  input  logic [2:0]  host_pixel,
  input  logic [23:0] host_grb,
  input  logic        commit,
  input  logic        refresh_en,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  color_level,
  output logic [1:0]  color_index,
  output logic [2:0]  pixel_index,
  output logic        load_color,
  output logic        send_it,
  input  logic        ready_to_load,
  input  logic        ready_to_send
);

  localparam int KW = $clog2(3 * NUM_PIXELS + 1);
  localparam int RW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [KW-1:0] K_LAST  = KW'(3 * NUM_PIXELS - 1);
  localparam logic [RW-1:0] RF_LAST = RW'(REFRESH_CYCLES - 1);

  seq_state_t  r_state, w_next;
  logic [23:0] r_shadow     [NUM_PIXELS];
  logic [23:0] r_active     [NUM_PIXELS];
  logic [23:0] w_shadow_nxt [NUM_PIXELS];
  logic [23:0] w_active_nxt [NUM_PIXELS];
  logic        r_pending;
  logic [KW-1:0] w_k, w_k_d, w_kcur;
  logic [RW-1:0] w_rf, w_rf_d;
  logic        w_k_en, w_k_clear, w_rf_en, w_rf_clear;
  logic        w_idle, w_rdy, w_expire, w_start, w_copy;
  logic        w_issue, w_send, w_done;
  logic [2:0]  w_pix;
  color_idx_t  w_col;
  logic        r_busy, r_done, r_load, r_send;
  logic [7:0]  r_level;
  logic [1:0]  r_cidx;
  logic [2:0]  r_pidx;

  assign w_idle   = (r_state == S_IDLE);
  assign w_rdy    = ready_to_load && ready_to_send;
  assign w_rf_en  = w_idle && refresh_en;
  assign w_expire = w_rf_en && (w_rf == RF_LAST);
  assign w_copy   = w_idle && (r_pending || commit);
  assign w_start  = w_copy || w_expire;

  // The first load is issued on the IDLE->LOAD edge, so k=0 is presented there.
  assign w_kcur     = w_idle ? '0 : w_k;
  assign w_pix      = 3'(w_kcur / KW'(3));
  assign w_col      = color_idx_t'(2'(w_kcur % KW'(3)));
  assign w_k_en     = w_issue;
  assign w_k_clear  = w_idle && !w_issue;
  assign w_k_d      = w_idle ? KW'(1) : w_k + KW'(1);
  assign w_rf_clear = !w_rf_en || w_start;
  assign w_rf_d     = w_rf + RW'(1);

  counter #(.W(KW)) u_load_idx (
    .clock(clock), .reset(reset), .en(w_k_en), .clear(w_k_clear), .d(w_k_d), .q(w_k)
  );

  counter #(.W(RW)) u_refresh (
    .clock(clock), .reset(reset), .en(w_rf_en), .clear(w_rf_clear), .d(w_rf_d), .q(w_rf)
  );

  // Same-cycle host write lands in the shadow before a commit copies it.
  always_comb begin
    for (int i = 0; i < NUM_PIXELS; i++) begin
      w_shadow_nxt[i] = (host_wr && host_pixel == 3'(i)) ? host_grb : r_shadow[i];
      w_active_nxt[i] = w_copy ? w_shadow_nxt[i] : r_active[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PIXELS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_pending <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_PIXELS; i++) begin
        r_shadow[i] <= w_shadow_nxt[i];
        r_active[i] <= w_active_nxt[i];
      end
      r_pending <= w_idle ? 1'b0 : (r_pending || commit);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_send  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next  = S_LOAD;
          w_issue = w_rdy;
        end
      end
      S_LOAD: begin
        if (w_rdy) begin
          w_issue = 1'b1;
          if (w_k == K_LAST) w_next = S_SEND;
        end
      end
      S_SEND: begin
        if (ready_to_send) begin
          w_send = 1'b1;
          w_next = S_ACK;
        end
      end
      S_ACK:   if (!ready_to_send) w_next = S_DRAIN;
      S_DRAIN: begin
        if (ready_to_send) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // busy stays up through the frame_done cycle and drops on the following one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_load  <= 1'b0;
      r_send  <= 1'b0;
      r_level <= '0;
      r_cidx  <= '0;
      r_pidx  <= '0;
    end else begin
      r_busy <= (w_next != S_IDLE) || w_done;
      r_done <= w_done;
      r_load <= w_issue;
      r_send <= w_send;
      if (w_issue) begin
        r_level <= grb_byte(grb_t'(w_active_nxt[w_pix]), w_col);
        r_cidx  <= w_col;
        r_pidx  <= w_pix;
      end
    end
  end

  assign busy        = r_busy;
  assign frame_done  = r_done;
  assign load_color  = r_load;
  assign send_it     = r_send;
  assign color_level = r_level;
  assign color_index = r_cidx;
  assign pixel_index = r_pidx;

endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// Directed bench for neopixel_frame_sequencer with a small strand-controller
// model that drops ready_to_send for a few cycles after each send_it.
module tb_neopixel_frame_sequencer;

  localparam int NP = 5;

  typedef struct packed {
    logic [2:0] pix;
    logic [1:0] col;
    logic [7:0] lvl;
  } vec_t;

  typedef struct packed {
    logic [2:0]  pix;
    logic [1:0]  col;
    logic [7:0]  lvl;
    logic [31:0] cyc;
  } ld_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        host_wr = 1'b0;
  logic [2:0]  host_pixel = '0;
  logic [23:0] host_grb = '0;
  logic        commit = 1'b0;
  logic        refresh_en = 1'b0;
  logic        ready_to_load = 1'b1;
  logic        ready_to_send;
  logic        busy, frame_done, load_color, send_it;
  logic [7:0]  color_level;
  logic [1:0]  color_index;
  logic [2:0]  pixel_index;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int overlap = 0;
  ld_t loads[$];
  int  send_cyc[$];
  int  done_cyc[$];
  logic [NP*24-1:0] m_shadow = '0;
  logic [NP*24-1:0] m_active = '0;
  vec_t tbl [15];

  neopixel_frame_sequencer #(.NUM_PIXELS(NP), .REFRESH_CYCLES(100)) dut (
    .clock(clock), .reset(reset), .host_wr(host_wr), .host_pixel(host_pixel),
    .host_grb(host_grb), .commit(commit), .refresh_en(refresh_en), .busy(busy),
    .frame_done(frame_done), .color_level(color_level), .color_index(color_index),
    .pixel_index(pixel_index), .load_color(load_color), .send_it(send_it),
    .ready_to_load(ready_to_load), .ready_to_send(ready_to_send)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Strand model: accept the send, then hold off for the bitstream + latch gap.
  initial begin
    ready_to_send = 1'b1;
    forever begin
      @(negedge clock);
      if (send_it) begin
        ready_to_send = 1'b0;
        repeat (3) @(negedge clock);
        ready_to_send = 1'b1;
      end
    end
  end

  initial begin
    ld_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (load_color) begin
          e.pix = pixel_index; e.col = color_index; e.lvl = color_level; e.cyc = 32'(cyc);
          loads.push_back(e);
        end
        if (send_it) send_cyc.push_back(cyc);
        if (frame_done) done_cyc.push_back(cyc);
        if (load_color && send_it) overlap++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic ld_t get_ld(input int idx);
    if (idx < loads.size()) return loads[idx];
    return '0;
  endfunction

  function automatic int get_q(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  task automatic clear_log();
    loads.delete(); send_cyc.delete(); done_cyc.delete();
  endtask

  task automatic host_write(input int p, input logic [23:0] v);
    @(posedge clock); #1;
    host_wr = 1'b1; host_pixel = 3'(p); host_grb = v;
    if (p < NP) m_shadow[p*24 +: 24] = v;
    @(posedge clock); #1;
    host_wr = 1'b0;
  endtask

  task automatic pulse_commit(output int tc);
    @(posedge clock); #1;
    commit = 1'b1; tc = cyc;
    @(posedge clock); #1;
    commit = 1'b0;
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) begin @(posedge clock); #1; end
  endtask

  task automatic wait_done(input int n);
    int i;
    i = 0;
    while (done_cyc.size() < n && i < 1000) begin @(negedge clock); #1; i++; end
    chk("frame_done_seen", 64'(done_cyc.size() >= n), 64'd1);
  endtask

  task automatic check_frame(input string name, input int base, input logic [NP*24-1:0] exp);
    logic [23:0] px;
    logic [7:0]  lv;
    ld_t a;
    for (int k = 0; k < 3*NP; k++) begin
      px = exp[(k/3)*24 +: 24];
      case (k % 3)
        0:       lv = px[15:8];
        1:       lv = px[7:0];
        default: lv = px[23:16];
      endcase
      a = get_ld(base + k);
      chk(name, {a.pix, a.col, a.lvl}, {3'(k/3), 2'(k%3), lv});
    end
  endtask

  initial begin
    int t, d;
    ld_t a;

    tbl = '{'{3'd0, 2'd0, 8'h00}, '{3'd0, 2'd1, 8'h00}, '{3'd0, 2'd2, 8'h00},
            '{3'd1, 2'd0, 8'h00}, '{3'd1, 2'd1, 8'h00}, '{3'd1, 2'd2, 8'h00},
            '{3'd2, 2'd0, 8'h22}, '{3'd2, 2'd1, 8'h33}, '{3'd2, 2'd2, 8'h11},
            '{3'd3, 2'd0, 8'h00}, '{3'd3, 2'd1, 8'h00}, '{3'd3, 2'd2, 8'h00},
            '{3'd4, 2'd0, 8'h00}, '{3'd4, 2'd1, 8'h00}, '{3'd4, 2'd2, 8'h00}};

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", {busy, frame_done, load_color, send_it, pixel_index, color_index, color_level}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock); #1;
    chk("idle_after_reset", {busy, load_color, send_it}, 0);

    // Single commit, strand always ready: table-driven load check
    clear_log();
    host_write(2, 24'h112233);
    pulse_commit(t);
    m_active = m_shadow;
    wait_done(1);
    chk("t1_busy_on_done", busy, 1);
    @(posedge clock); #1;
    chk("t1_busy_after_done", busy, 0);
    chk("t1_load_count", loads.size(), 15);
    for (int k = 0; k < 15; k++) begin
      a = get_ld(k);
      chk("t1_load", {a.pix, a.col, a.lvl, a.cyc}, {tbl[k], 32'(t + 1 + k)});
    end
    chk("t1_send_cycle", get_q(send_cyc, 0), t + 16);
    chk("t1_send_count", send_cyc.size(), 1);

    // Stall: ready_to_load low for 4 cycles at k=5
    clear_log();
    host_write(1, 24'h445566);
    pulse_commit(t);
    m_active = m_shadow;
    wait_cycle(t + 5);
    ready_to_load = 1'b0;
    wait_cycle(t + 9);
    ready_to_load = 1'b1;
    wait_done(1);
    chk("t2_load_count", loads.size(), 15);
    check_frame("t2_frame", 0, m_active);
    chk("t2_k4_cycle", get_ld(4).cyc, t + 5);
    chk("t2_k5_cycle", get_ld(5).cyc, t + 10);
    chk("t2_send_cycle", get_q(send_cyc, 0), t + 20);

    // Commit during ACK: first frame keeps old data, second follows from IDLE
    clear_log();
    host_write(0, 24'hAABBCC);
    pulse_commit(t);
    m_active = m_shadow;
    for (int i = 0; i < 200 && !send_it; i++) begin @(posedge clock); #1; end
    chk("t3_send_seen", send_it, 1);
    host_wr = 1'b1; host_pixel = 3'd0; host_grb = 24'h010203; commit = 1'b1;
    m_shadow[23:0] = 24'h010203;
    @(posedge clock); #1;
    host_wr = 1'b0; commit = 1'b0;
    wait_done(2);
    chk("t3_load_count", loads.size(), 30);
    check_frame("t3_frame1_old", 0, m_active);
    check_frame("t3_frame2_new", 15, m_shadow);
    chk("t3_frame2_start", get_ld(15).cyc, get_q(done_cyc, 0) + 1);
    m_active = m_shadow;

    // Periodic refresh, then commit on the expiry cycle
    clear_log();
    @(posedge clock); #1;
    refresh_en = 1'b1;
    t = cyc;
    wait_done(1);
    chk("t4_first_start", get_ld(0).cyc, t + 100);
    check_frame("t4_refresh_frame", 0, m_active);
    wait_done(2);
    chk("t4_period", get_ld(15).cyc, get_q(done_cyc, 0) + 100);
    d = get_q(done_cyc, 1);
    host_write(4, 24'h778899);
    wait_cycle(d + 99);
    commit = 1'b1;
    @(posedge clock); #1;
    commit = 1'b0; refresh_en = 1'b0;
    m_active = m_shadow;
    wait_done(3);
    repeat (40) @(posedge clock); #1;
    chk("t4_single_frame_loads", loads.size(), 45);
    chk("t4_single_frame_dones", done_cyc.size(), 3);
    chk("t4_commit_expiry_start", get_ld(30).cyc, d + 100);
    check_frame("t4_commit_frame", 30, m_active);
    chk("t4_idle_busy", busy, 0);

    // Out-of-range host writes are dropped
    clear_log();
    host_write(5, 24'hFFFFFF);
    host_write(7, 24'hEEEEEE);
    host_write(3, 24'h9ABCDE);
    pulse_commit(t);
    m_active = m_shadow;
    wait_done(1);
    check_frame("t6_frame", 0, m_active);

    // Reset mid-LOAD at k=7, then a commit of the cleared buffers
    clear_log();
    pulse_commit(t);
    wait_cycle(t + 8);
    chk("t5_k7_visible", {load_color, pixel_index, color_index}, {1'b1, 3'd2, 2'd1});
    reset = 1'b1;
    @(posedge clock); #1;
    chk("t5_reset_outputs", {busy, frame_done, load_color, send_it, pixel_index, color_index, color_level}, 0);
    reset = 1'b0;
    m_shadow = '0; m_active = '0;
    repeat (4) @(posedge clock); #1;
    chk("t5_no_resume", {busy, load_color, send_it}, 0);
    clear_log();
    pulse_commit(t);
    wait_done(1);
    chk("t5_zero_load_count", loads.size(), 15);
    check_frame("t5_zero_frame", 0, '0);

    chk("load_send_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neopixel_frame_sequencer.md
# neopixel_frame_sequencer

Frame-level sequencer that drives the NeoPixel strand controller's load/send handshake. A host writes 24-bit GRB pixel values into a shadow frame buffer and issues `commit`. The block then streams every colour byte into the strand controller, one `load_color` per cycle, and pulses `send_it`. It can also re-send the active frame periodically. It sits between host/pattern logic and the strand controller; the host never touches `color_index`/`pixel_index` directly.

## Interface
Parameters:
- `NUM_PIXELS`, default 5: pixels on the strand; must match the strand controller.
- `REFRESH_CYCLES`, default 2_500_000: auto-refresh period in clocks (50 ms at 50 MHz).

Ports:
- `clock`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high.
- `host_wr`  in  1  write `host_grb` into shadow entry `host_pixel`.
- `host_pixel`  in  3  pixel index; writes with `host_pixel >= NUM_PIXELS` are ignored.
- `host_grb`  in  24  {G[23:16], R[15:8], B[7:0]}.
- `commit`  in  1  copy shadow to active and request a frame.
- `refresh_en`  in  1  enable periodic re-send of the active frame.
- `busy`  out  1  frame in progress (any state other than IDLE).
- `frame_done`  out  1  one-cycle pulse when the strand returns ready after a send.
- `color_level`  out  8  to strand.
- `color_index`  out  2  to strand: 00 red, 01 blue, 10 green.
- `pixel_index`  out  3  to strand.
- `load_color`  out  1  to strand.
- `send_it`  out  1  to strand.
- `ready_to_load`  in  1  from strand.
- `ready_to_send`  in  1  from strand.

## Operation
- Storage: shadow[NUM_PIXELS] and active[NUM_PIXELS], each 24 bits. Both are zero on reset.
- On `commit`, active ← shadow. A `host_wr` in the same cycle is included in the copy.
- Commit pending flag:
  - Set by `commit` in any state.
  - Cleared when a frame starts from IDLE.
  - A commit while busy is serviced immediately after return to IDLE; the copy happens then, not earlier.
- Refresh counter runs only in IDLE while `refresh_en` is high. Otherwise it clears.
  - At `REFRESH_CYCLES-1` it starts a frame and clears.
  - Commit and refresh in the same cycle: one frame starts, the counter clears, and the pending flag clears.
- States:
  - IDLE: on pending, commit, or refresh, go to LOAD. The load index `k` resets to 0.
  - LOAD:
    - When `ready_to_load && ready_to_send`, assert `load_color` and increment `k`. Otherwise hold `k` with `load_color` low.
    - Mapping: pixel = k/3, colour = k%3 in order red, blue, green. `color_level` is the matching byte of active[pixel].
    - After the last load (k = 3·NUM_PIXELS−1 accepted), go to SEND.
  - SEND: when `ready_to_send`, pulse `send_it` for one cycle and go to ACK.
  - ACK: wait for `ready_to_send` low (send accepted), then go to DRAIN.
  - DRAIN: wait for `ready_to_send` high (strand has finished the bitstream and its 50 µs latch gap). Pulse `frame_done` and go to IDLE.
- `load_color` and `send_it` are never high together.
- `host_wr` is accepted in every state; it affects only the shadow buffer.
- `reset` mid-frame returns to IDLE immediately, with all outputs and both buffers zero. No partial frame is resumed.

## Timing
- All strand-side outputs and `busy`/`frame_done` are registered. Reset value of every output is 0.
- Commit asserted in cycle t from IDLE, strand ready throughout:
  - `busy` high from t+1.
  - `load_color` high in cycles t+1 … t+3·NUM_PIXELS (15 cycles at default).
  - `send_it` high at t+3·NUM_PIXELS+1.
- Stall: `ready_to_load` or `ready_to_send` low during LOAD extends LOAD one cycle per stalled cycle. Values presented on a stalled cycle are not counted.
- `frame_done` is high in the single cycle the block re-enters IDLE. `busy` is low from the next cycle.
- Refresh period is measured from IDLE entry to the next frame start: REFRESH_CYCLES clocks.

## Structure
- Shared package `neopixel_pkg`:
  - `color_idx_t` enum (COLOR_RED=2'b00, COLOR_BLUE=2'b01, COLOR_GREEN=2'b10).
  - `grb_t` packed struct {g, r, b}.
  - Sequencer state enum (IDLE, LOAD, SEND, ACK, DRAIN).
  - Constant `CLK_HZ = 50_000_000`.
- Sub-module: the existing generic `counter` (en/clear/d/q). Instantiate it for the load index and for the refresh timer.

## Test plan
- Write pixel 2 = 24'h11_22_33, commit, strand ready → 15 loads. The loads at k=6,7,8 carry pixel_index 2 with (idx 00, 8'h22), (01, 8'h33), (10, 8'h11). `send_it` follows in the next cycle.
- Hold `ready_to_load` low for 4 cycles at k=5 → exactly 15 `load_color` pulses; `send_it` is delayed by 4 cycles; no duplicate or skipped k.
- Commit during ACK with new shadow data → the first frame finishes with old data. `frame_done` pulses, then a second frame starts from IDLE carrying the new data.
- `refresh_en`=1, REFRESH_CYCLES=100, no commit → frames start every 100 idle cycles. Commit in the same cycle as expiry → a single frame.
- Reset asserted mid-LOAD at k=7 → next cycle all outputs 0, IDLE, `busy` 0. A later commit of zeros sends all-zero levels.
- `host_wr` with `host_pixel` = 5 (NUM_PIXELS=5) → ignored; the next frame is unchanged.
